uart: RTL and testbench

UART -- requirements
Module: uart

---
 rtl/uart_pkg.sv | 5 +
 rtl/uart_prescaler.sv | 20 ++
 rtl/uart_rx.sv | 103 ++++++++++
 rtl/uart_tx.sv | 81 ++++++++
 rtl/uart.sv | 42 ++++
 tb/tb_uart.sv | 202 ++++++++++++++++++++
 6 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling rate.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
    localparam int TICKS_PER_BIT = 16;
endpackage

// File: rtl/uart_prescaler.sv
// Free-running prescaler: one-cycle tick enable every 2^br sysclk cycles.
module uart_prescaler #(
    parameter logic [2:0] br = 3'b000
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);
    localparam logic [6:0] MASK = 7'((8'd1 << br) - 8'd1);

    logic [6:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_q + 7'd1;
    end

    // br=0 gives an all-zero mask, so the tick is asserted every cycle.
    assign tick_o = (cnt_q & MASK) == MASK;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronized input, mid-bit sampling, framing-error rejection.
module uart_rx import uart_pkg::*; #(
    parameter int data_bits = 8,
    parameter int received_bit_counter_bits = 3,
    parameter int bit_cell_counter_bits = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 tick_i,
    input  logic                 rxd_i,
    output logic [data_bits-1:0] rdr_o,
    output logic                 ready_o
);
    localparam int RW = received_bit_counter_bits;
    localparam int CW = bit_cell_counter_bits;
    localparam logic [CW-1:0] CELL_MID  = CW'(TICKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CELL_LAST = CW'(TICKS_PER_BIT - 1);
    localparam logic [RW-1:0] LAST_IDX  = RW'(data_bits - 1);

    state_e               state_q, state_d;
    logic                 sync1_q, rxs_q;
    logic [CW-1:0]        cell_q;
    logic [RW-1:0]        bit_q;
    logic [data_bits-1:0] shreg_q, rdr_q;
    logic                 ready_q, ferr_q;
    logic                 at_mid, at_last;

    assign at_mid  = tick_i && (cell_q == CELL_MID);
    // After the start bit's midpoint the counter restarts, so a full cell lands mid-bit.
    assign at_last = tick_i && (cell_q == CELL_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            state_q <= IDLE;
        end else begin
            sync1_q <= rxd_i;
            rxs_q   <= sync1_q;
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!rxs_q) state_d = START;
            START: if (at_mid) state_d = rxs_q ? IDLE : DATA;
            DATA:  if (at_last && bit_q == LAST_IDX) state_d = STOP;
            STOP: begin
                if (ferr_q) begin
                    if (rxs_q) state_d = IDLE;
                end else if (at_last && rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cell_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            rdr_q   <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cell_q <= '0;
                    bit_q  <= '0;
                    ferr_q <= 1'b0;
                end
                START: if (tick_i) cell_q <= at_mid ? '0 : cell_q + 1'b1;
                DATA: if (tick_i) begin
                    cell_q <= at_last ? '0 : cell_q + 1'b1;
                    if (at_last) begin
                        shreg_q <= {rxs_q, shreg_q[data_bits-1:1]};
                        bit_q   <= bit_q + 1'b1;
                    end
                end
                STOP: if (!ferr_q && tick_i) begin
                    cell_q <= at_last ? '0 : cell_q + 1'b1;
                    if (at_last) begin
                        if (rxs_q) begin
                            rdr_q   <= shreg_q;
                            ready_q <= 1'b1;
                        end else begin
                            ferr_q  <= 1'b1;
                        end
                    end
                end
                default: cell_q <= '0;
            endcase
        end
    end

    assign rdr_o   = rdr_q;
    assign ready_o = ready_q;
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, stop; 16 ticks per bit.
module uart_tx import uart_pkg::*; #(
    parameter int data_bits = 8,
    parameter int transmitted_bit_counter_bits = 4,
    parameter int bit_cell_counter_bits = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 tick_i,
    input  logic [data_bits-1:0] data_i,
    input  logic                 start_i,
    output logic                 txd_o,
    output logic                 done_o
);
    localparam int BW = transmitted_bit_counter_bits;
    localparam int CW = bit_cell_counter_bits;
    localparam logic [CW-1:0] CELL_LAST = CW'(TICKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(data_bits);

    state_e               state_q, state_d;
    logic [CW-1:0]        cell_q;
    logic [BW-1:0]        bit_q;
    logic [data_bits-1:0] shreg_q;
    logic                 done_q;
    logic                 bit_end, load;

    assign bit_end = tick_i && (cell_q == CELL_LAST);
    // A request still high at the end of STOP chains straight into the next START.
    assign load    = start_i && (state_q == IDLE || (state_q == STOP && bit_end));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start_i) state_d = START;
            START: if (bit_end) state_d = DATA;
            DATA:  if (bit_end && bit_q == LAST_DATA) state_d = STOP;
            STOP:  if (bit_end) state_d = start_i ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cell_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                shreg_q <= data_i;
                cell_q  <= '0;
                bit_q   <= '0;
                if (state_q == STOP) done_q <= 1'b1;
            end else if (state_q != IDLE && tick_i) begin
                cell_q <= bit_end ? '0 : cell_q + 1'b1;
                if (bit_end) begin
                    bit_q <= bit_q + 1'b1;
                    if (state_q == DATA) shreg_q <= shreg_q >> 1;
                    if (state_q == STOP) done_q  <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        txd_o = 1'b1;
        case (state_q)
            START:   txd_o = 1'b0;
            DATA:    txd_o = shreg_q[0];
            default: txd_o = 1'b1;
        endcase
    end

    assign done_o = done_q;
endmodule

// File: rtl/uart.sv
// UART top: shared prescaler driving independent transmitter and receiver.
module uart #(
    parameter int         data_bits = 8,
    parameter int         transmitted_bit_counter_bits = 4,
    parameter int         received_bit_counter_bits = 3,
    parameter int         bit_cell_counter_bits = 4,
    parameter logic [2:0] br = 3'b000
) (
    input  logic                 sysclk,
    input  logic                 rst_n,
    input  logic [data_bits-1:0] DBUS,
    input  logic                 txd_startH,
    output logic                 txd,
    output logic                 txd_doneH,
    input  logic                 rxd,
    output logic [data_bits-1:0] RDR,
    output logic                 rxd_readyH
);
    logic tick;

    uart_prescaler #(.br(br)) u_presc (
        .clk_i(sysclk), .rst_ni(rst_n), .tick_o(tick)
    );

    uart_tx #(
        .data_bits(data_bits),
        .transmitted_bit_counter_bits(transmitted_bit_counter_bits),
        .bit_cell_counter_bits(bit_cell_counter_bits)
    ) u_tx (
        .clk_i(sysclk), .rst_ni(rst_n), .tick_i(tick), .data_i(DBUS),
        .start_i(txd_startH), .txd_o(txd), .done_o(txd_doneH)
    );

    uart_rx #(
        .data_bits(data_bits),
        .received_bit_counter_bits(received_bit_counter_bits),
        .bit_cell_counter_bits(bit_cell_counter_bits)
    ) u_rx (
        .clk_i(sysclk), .rst_ni(rst_n), .tick_i(tick), .rxd_i(rxd),
        .rdr_o(RDR), .ready_o(rxd_readyH)
    );
endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: TX waveform, loopback scoreboard, RX error cases, reset.
module tb_uart;
    logic       sysclk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] DBUS = 8'h00;
    logic       txd_startH = 1'b0;
    logic       txd, txd_doneH, rxd_readyH, rxd;
    logic [7:0] RDR;
    logic       loop_en = 1'b0, rxd_drv = 1'b1, txd_ff = 1'b1;

    int         total = 0, bad = 0, ready_cnt = 0, done_cnt = 0;
    logic [7:0] sb[$];

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) txd_ff <= txd;
    assign rxd = loop_en ? txd_ff : rxd_drv;

    uart #(.br(3'b000)) dut (
        .sysclk(sysclk), .rst_n(rst_n), .DBUS(DBUS), .txd_startH(txd_startH),
        .txd(txd), .txd_doneH(txd_doneH), .rxd(rxd), .RDR(RDR), .rxd_readyH(rxd_readyH)
    );

    // Advance one cycle; every ready pulse is checked against the scoreboard.
    task automatic step();
        logic [7:0] e;
        @(negedge sysclk);
        if (txd_doneH) done_cnt++;
        if (rxd_readyH) begin
            ready_cnt++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL rx_unexpected: RDR=%h, no word was expected", RDR);
            end else begin
                e = sb.pop_front();
                if (RDR !== e) begin
                    bad++;
                    $display("FAIL rx_word: RDR=%h, expected %h", RDR, e);
                end
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (txd_doneH) begin ok = 1'b1; break; end
        end
    endtask

    task automatic send_serial(input logic [7:0] w, input logic stopb);
        logic [9:0] fr;
        fr = {stopb, w, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rxd_drv = fr[b];
            steps(16);
        end
        rxd_drv = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++; if (txd !== 1'b1)        begin bad++; $display("FAIL rst_txd: got %b, expected 1", txd); end
        total++; if (RDR !== 8'h00)       begin bad++; $display("FAIL rst_rdr: got %h, expected 00", RDR); end
        total++; if (rxd_readyH !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b, expected 0", rxd_readyH); end
        total++; if (txd_doneH !== 1'b0)  begin bad++; $display("FAIL rst_done: got %b, expected 0", txd_doneH); end
        repeat (3) @(negedge sysclk);
        rst_n = 1'b1;
        steps(3);
    endtask

    task automatic test_tx_pattern();
        logic [9:0] exp_bits;
        int         errs;
        exp_bits = {1'b1, 8'h85, 1'b0};
        loop_en = 1'b0; rxd_drv = 1'b1;
        step(); DBUS = 8'h85; txd_startH = 1'b1;
        step(); txd_startH = 1'b0; DBUS = 8'h00;
        for (int b = 0; b < 10; b++) begin
            errs = 0;
            for (int c = 0; c < 16; c++) begin
                if (txd !== exp_bits[b] || txd_doneH !== 1'b0) errs++;
                step();
            end
            total++;
            if (errs != 0) begin
                bad++;
                $display("FAIL tx_bit%0d: %0d wrong cycles, expected txd=%b and no done for 16 cycles", b, errs, exp_bits[b]);
            end
        end
        total++; if (txd_doneH !== 1'b1) begin bad++; $display("FAIL tx_done_latency: done=%b at cycle 160, expected 1", txd_doneH); end
        step();
        total++; if (txd_doneH !== 1'b0 || txd !== 1'b1) begin
            bad++; $display("FAIL tx_done_width: done=%b txd=%b, expected 0 and 1", txd_doneH, txd);
        end
    endtask

    task automatic test_loopback();
        int r0;
        bit ok;
        loop_en = 1'b1;
        r0 = ready_cnt;
        sb.push_back(8'hA5);
        step(); DBUS = 8'hA5; txd_startH = 1'b1;
        step(); txd_startH = 1'b0; DBUS = 8'h5A;
        wait_done(400, ok);
        total++; if (!ok) begin bad++; $display("FAIL lb_done: no done within 400 cycles, expected one"); end
        steps(20);
        total++; if (ready_cnt - r0 != 1) begin bad++; $display("FAIL lb_ready_count: got %0d, expected 1", ready_cnt - r0); end
        total++; if (RDR !== 8'hA5) begin bad++; $display("FAIL lb_rdr: got %h, expected a5", RDR); end
    endtask

    task automatic test_back_to_back();
        int r0;
        bit ok;
        r0 = ready_cnt;
        repeat (3) sb.push_back(8'h3C);
        step(); DBUS = 8'h3C; txd_startH = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_done(400, ok);
            total++; if (!ok) begin bad++; $display("FAIL b2b_done%0d: no done within 400 cycles", k); end
            total++;
            if (txd !== (k == 2 ? 1'b1 : 1'b0)) begin
                bad++; $display("FAIL b2b_gap%0d: txd=%b at done, expected %b", k, txd, (k == 2));
            end
            if (k == 1) txd_startH = 1'b0;
        end
        txd_startH = 1'b0;
        steps(20);
        total++; if (ready_cnt - r0 != 3) begin bad++; $display("FAIL b2b_ready_count: got %0d, expected 3", ready_cnt - r0); end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL b2b_pending: %0d words never received, expected 0", sb.size()); end
    endtask

    task automatic test_glitch();
        int r0;
        loop_en = 1'b0; rxd_drv = 1'b1;
        steps(5);
        r0 = ready_cnt;
        rxd_drv = 1'b0; steps(4); rxd_drv = 1'b1;
        steps(300);
        total++; if (ready_cnt != r0) begin bad++; $display("FAIL glitch_ready: %0d pulses, expected 0", ready_cnt - r0); end
        total++; if (RDR !== 8'h3C) begin bad++; $display("FAIL glitch_rdr: got %h, expected 3c", RDR); end
    endtask

    task automatic test_framing();
        int r0;
        r0 = ready_cnt;
        send_serial(8'h55, 1'b0);
        steps(40);
        total++; if (ready_cnt != r0) begin bad++; $display("FAIL ferr_ready: %0d pulses, expected 0", ready_cnt - r0); end
        total++; if (RDR !== 8'h3C) begin bad++; $display("FAIL ferr_rdr: got %h, expected 3c", RDR); end
        sb.push_back(8'h12);
        send_serial(8'h12, 1'b1);
        steps(40);
        total++; if (ready_cnt - r0 != 1) begin bad++; $display("FAIL ferr_next_count: got %0d, expected 1", ready_cnt - r0); end
        total++; if (RDR !== 8'h12) begin bad++; $display("FAIL ferr_next_rdr: got %h, expected 12", RDR); end
    endtask

    task automatic test_reset_midframe();
        int r0, d0;
        loop_en = 1'b1;
        r0 = ready_cnt; d0 = done_cnt;
        step(); DBUS = 8'h77; txd_startH = 1'b1;
        step(); txd_startH = 1'b0;
        steps(60);
        rst_n = 1'b0;
        #1;
        total++; if (txd !== 1'b1 || txd_doneH !== 1'b0) begin
            bad++; $display("FAIL mid_rst_tx: txd=%b done=%b, expected 1 and 0", txd, txd_doneH);
        end
        total++; if (RDR !== 8'h00) begin bad++; $display("FAIL mid_rst_rdr: got %h, expected 00", RDR); end
        @(negedge sysclk); rst_n = 1'b1;
        steps(300);
        total++; if (ready_cnt != r0 || done_cnt != d0) begin
            bad++; $display("FAIL mid_rst_pulses: ready=%0d done=%0d, expected 0 and 0", ready_cnt - r0, done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_tx_pattern();
        test_loopback();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
